// File: rtl/mips_data_ram.sv
// MIPS data RAM: combinational CPU read, single-cycle CPU write,
// plus a low-priority debug port with a one-cycle ack handshake.
module mips_data_ram #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 1024,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_enable,
    input  logic [31:0]   data_address,
    input  logic          data_write,
    input  logic          data_read,
    input  logic [31:0]   data_writedata,
    output logic [31:0]   data_readdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic [31:0]   dbg_rdata,
    output logic          dbg_ack,
    output logic          access_err,
    output logic [15:0]   wr_count
);

    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic {IDLE, ACK} dbg_state_t;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   offset;
    logic          in_range;
    logic          valid;
    logic [AW-1:0] idx;
    logic          cpu_busy;
    logic          cpu_bad;
    logic          cpu_wr;
    logic          dbg_go;
    logic          dbg_wr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    dbg_state_t    state_q, state_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [15:0]   cnt_q, cnt_d;

    assign offset   = data_address - BASE_ADDR;
    assign in_range = (data_address >= BASE_ADDR) && (offset < SPAN);
    assign valid    = in_range && (data_address[1:0] == 2'b00);
    assign idx      = offset[AW+1:2];
    assign cpu_busy = data_write | data_read;
    assign cpu_bad  = cpu_busy && (!valid || (data_write && data_read));
    assign cpu_wr   = clk_enable && data_write && !data_read && valid && !reset;

    // CPU always wins; debug is only accepted in a fully idle CPU cycle
    assign dbg_go = (state_q == IDLE) && dbg_req && !cpu_busy;
    assign dbg_wr = dbg_go && dbg_we && !reset;

    always_comb begin
        mem_we    = cpu_wr | dbg_wr;
        mem_waddr = cpu_wr ? idx : dbg_addr;
        mem_wdata = cpu_wr ? data_writedata : dbg_wdata;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        data_readdata = 32'h0;
        if (data_read && !data_write && valid) data_readdata = mem[idx];
    end

    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (clk_enable) begin
            if (cpu_bad) err_d = 1'b1;
            if (cpu_wr && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (dbg_go && !dbg_we) rdata_d = mem[dbg_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (dbg_go) state_d = ACK;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset during ACK masks the pulse that would otherwise still show
    always_comb begin
        dbg_ack    = (state_q == ACK) && !reset;
        dbg_rdata  = rdata_q;
        access_err = err_q;
        wr_count   = cnt_q;
    end

endmodule

// File: tb/tb_mips_data_ram.sv
// Directed bench for mips_data_ram: CPU read/write, error flag,
// write counter, debug handshake and reset behaviour.
module tb_mips_data_ram;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        dbg_req;
    logic        dbg_we;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;
    logic        access_err;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    mips_data_ram dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_rdata      (dbg_rdata),
        .dbg_ack        (dbg_ack),
        .access_err     (access_err),
        .wr_count       (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        data_address   = a;
        data_writedata = d;
        data_write     = 1'b1;
        data_read      = 1'b0;
        tick();
        data_write     = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [31:0] a,
                            input logic [31:0] exp);
        data_address = a;
        data_read    = 1'b1;
        data_write   = 1'b0;
        #1;
        chk(tag, data_readdata, exp);
        data_read    = 1'b0;
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        clk_enable     = 1'b1;
        data_address   = 32'h0;
        data_write     = 1'b0;
        data_read      = 1'b0;
        data_writedata = 32'h0;
        dbg_req        = 1'b0;
        dbg_we         = 1'b0;
        dbg_addr       = 10'd0;
        dbg_wdata      = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_err", {31'h0, access_err}, 32'h0);
        chk("rst_cnt", {16'h0, wr_count}, 32'h0);
        chk("rst_ack", {31'h0, dbg_ack}, 32'h0);
        chk("rst_rdata", dbg_rdata, 32'h0);

        cpu_write(32'h1004, 32'hDEADBEEF);
        cpu_read("rd_1004", 32'h1004, 32'hDEADBEEF);
        chk("cnt_1", {16'h0, wr_count}, 32'd1);
        cpu_write(32'h1000, 32'hA5A5A5A5);
        cpu_write(32'h1008, 32'h11111111);
        chk("cnt_3", {16'h0, wr_count}, 32'd3);
        chk("err_clean", {31'h0, access_err}, 32'h0);

        cpu_write(32'h1002, 32'hFFFFFFFF);
        chk("err_misal", {31'h0, access_err}, 32'h1);
        cpu_write(32'h0FFC, 32'hFFFFFFFF);
        chk("cnt_bad", {16'h0, wr_count}, 32'd3);
        cpu_read("rd_1000", 32'h1000, 32'hA5A5A5A5);
        cpu_read("rd_misal", 32'h1006, 32'h0);
        cpu_read("rd_above", 32'h2000, 32'h0);

        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 10'd5;
        dbg_wdata = 32'h12345678;
        tick();
        chk("dbgw_ack", {31'h0, dbg_ack}, 32'h1);
        dbg_req = 1'b0;
        tick();
        chk("dbgw_ack_end", {31'h0, dbg_ack}, 32'h0);
        cpu_read("rd_1014", 32'h1014, 32'h12345678);
        chk("cnt_dbg", {16'h0, wr_count}, 32'd3);

        // debug read held off by three CPU read cycles, then re-requested
        dbg_req      = 1'b1;
        dbg_we       = 1'b0;
        dbg_addr     = 10'd1;
        data_address = 32'h1000;
        data_read    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dbg_wait", {31'h0, dbg_ack}, 32'h0);
        end
        data_read = 1'b0;
        tick();
        chk("dbgr_ack", {31'h0, dbg_ack}, 32'h1);
        chk("dbgr_data", dbg_rdata, 32'hDEADBEEF);
        tick();
        chk("dbgr_gap", {31'h0, dbg_ack}, 32'h0);
        dbg_addr = 10'd2;
        tick();
        chk("dbgr_again", {31'h0, dbg_ack}, 32'h1);
        chk("dbgr_data2", dbg_rdata, 32'h11111111);
        dbg_req = 1'b0;
        tick();
        chk("dbgr_end", {31'h0, dbg_ack}, 32'h0);
        chk("dbgr_hold", dbg_rdata, 32'h11111111);

        clk_enable = 1'b0;
        cpu_write(32'h1008, 32'hCAFEF00D);
        cpu_read("ce0_rd", 32'h1008, 32'h11111111);
        chk("ce0_cnt", {16'h0, wr_count}, 32'd3);
        dbg_req  = 1'b1;
        dbg_addr = 10'd0;
        tick();
        chk("ce0_dbg_ack", {31'h0, dbg_ack}, 32'h1);
        chk("ce0_dbg_data", dbg_rdata, 32'hA5A5A5A5);
        dbg_req = 1'b0;
        tick();
        clk_enable = 1'b1;
        cpu_write(32'h1008, 32'hCAFEF00D);
        cpu_read("ce1_rd", 32'h1008, 32'hCAFEF00D);
        chk("ce1_cnt", {16'h0, wr_count}, 32'd4);

        // reset with a pending write: nothing may be committed
        reset          = 1'b1;
        data_address   = 32'h1000;
        data_writedata = 32'h0;
        data_write     = 1'b1;
        tick();
        data_write = 1'b0;
        reset      = 1'b0;
        chk("rst2_err", {31'h0, access_err}, 32'h0);
        chk("rst2_cnt", {16'h0, wr_count}, 32'h0);
        chk("rst2_rdata", dbg_rdata, 32'h0);
        cpu_read("rst2_1000", 32'h1000, 32'hA5A5A5A5);
        cpu_read("rst2_1004", 32'h1004, 32'hDEADBEEF);
        cpu_read("rst2_1014", 32'h1014, 32'h12345678);

        clk_enable = 1'b0;
        cpu_write(32'h1001, 32'h0);
        chk("ce0_noerr", {31'h0, access_err}, 32'h0);
        clk_enable = 1'b1;
        data_address = 32'h100C;
        data_read    = 1'b1;
        data_write   = 1'b1;
        tick();
        data_read  = 1'b0;
        data_write = 1'b0;
        chk("err_both", {31'h0, access_err}, 32'h1);
        chk("cnt_both", {16'h0, wr_count}, 32'h0);

        // debug write, then reset in ACK: ack masked, data kept
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 10'd7;
        dbg_wdata = 32'h0BADF00D;
        tick();
        dbg_req = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rst_ack_mask", {31'h0, dbg_ack}, 32'h0);
        tick();
        reset = 1'b0;
        chk("rst_ack_idle", {31'h0, dbg_ack}, 32'h0);
        cpu_read("rd_101c", 32'h101C, 32'h0BADF00D);

        data_address   = 32'h1010;
        data_writedata = 32'h5;
        data_write     = 1'b1;
        for (int i = 0; i < 65537; i++) @(posedge clk);
        #1;
        data_write = 1'b0;
        chk("cnt_sat", {16'h0, wr_count}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
